// File: rtl/spi_pkg.sv
// Shared SPI master definitions: sizing constants and the transfer FSM state encoding.
package spi_pkg;

    localparam int unsigned SPI_DIVIDER_LEN   = 8;
    localparam int unsigned SPI_MAX_CHAR      = 32;
    localparam int unsigned SPI_CHAR_LEN_BITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load tx/rx shift pair with independent shift enables and MSB/LSB-first direction.
module spi_shift_reg #(
    parameter int unsigned MAX_CHAR = 32,
    parameter int unsigned CNT_W    = 6
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [MAX_CHAR-1:0] i_tx_load,
    input  logic                i_lsb,
    input  logic [CNT_W-1:0]    i_len,
    input  logic                i_tx_shift,
    input  logic                i_rx_shift,
    input  logic                i_miso,
    output logic                o_mosi,
    output logic [MAX_CHAR-1:0] o_rx_next_c
);

    logic [MAX_CHAR-1:0] tx_q, tx_d, rx_q, rx_d;
    logic                lsb_q, lsb_sel;

    // Next tx/rx contents; load clears rx so MSB-first results come out right-aligned.
    always_comb begin
        tx_d    = tx_q;
        rx_d    = rx_q;
        lsb_sel = i_load ? i_lsb : lsb_q;
        if (i_load) begin
            tx_d = i_tx_load;
            rx_d = '0;
        end else begin
            if (i_tx_shift) begin
                tx_d = lsb_q ? (tx_q >> 1) : (tx_q << 1);
            end
            if (i_rx_shift) begin
                rx_d = lsb_q ? ((rx_q >> 1) | (MAX_CHAR'(i_miso) << (i_len - CNT_W'(1))))
                             : {rx_q[MAX_CHAR-2:0], i_miso};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_q   <= '0;
            rx_q   <= '0;
            lsb_q  <= 1'b0;
            o_mosi <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            o_mosi <= lsb_sel ? tx_d[0] : tx_d[MAX_CHAR-1];
            if (i_load) begin
                lsb_q <= i_lsb;
            end
        end
    end

    assign o_rx_next_c = rx_d;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI character transfer sequencer driving spi_clk_gen; counts edge pulses to shift MOSI/MISO.
// Optional SPI_LSB_FIRST_EN adds the i_lsb port for LSB-first transfers.
module spi_xfer_ctrl #(
    parameter int unsigned SPI_DIVIDER_LEN   = spi_pkg::SPI_DIVIDER_LEN,
    parameter int unsigned SPI_MAX_CHAR      = spi_pkg::SPI_MAX_CHAR,
    parameter int unsigned SPI_CHAR_LEN_BITS = spi_pkg::SPI_CHAR_LEN_BITS
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [SPI_CHAR_LEN_BITS-1:0] i_char_len,
    input  logic [SPI_DIVIDER_LEN-1:0]   i_divider,
    input  logic                         i_tx_neg,
    input  logic [SPI_MAX_CHAR-1:0]      i_tx_data,
`ifdef SPI_LSB_FIRST_EN
    input  logic                         i_lsb,
`endif
    input  logic                         i_miso,
    input  logic                         i_pos_edge,
    input  logic                         i_neg_edge,
    output logic                         o_enable,
    output logic                         o_tx_start,
    output logic                         o_last_clk,
    output logic [SPI_DIVIDER_LEN-1:0]   o_divider,
    output logic                         o_mosi,
    output logic                         o_ss_n,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [SPI_MAX_CHAR-1:0]      o_rx_data
);

    import spi_pkg::*;

    localparam int unsigned CNT_W = SPI_CHAR_LEN_BITS + 1;

    spi_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, len_q, len_start;
    logic                    tx_neg_q, sampled_q;
    logic                    start_ok, sample_c, drive_c, lsb_start;
    logic [SPI_MAX_CHAR-1:0] tx_load, rx_next;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_start = i_lsb;
`else
    assign lsb_start = 1'b0;
`endif

    assign start_ok  = (state_q == IDLE) && i_start;
    assign len_start = (i_char_len == '0) ? CNT_W'(SPI_MAX_CHAR) : CNT_W'(i_char_len);
    // MSB-first: left-justify so bit char_len-1 sits at the shift-out end.
    assign tx_load   = lsb_start ? i_tx_data : (i_tx_data << (CNT_W'(SPI_MAX_CHAR) - len_start));
    assign sample_c  = (state_q == XFER) && (tx_neg_q ? i_pos_edge : i_neg_edge);
    assign drive_c   = (state_q == XFER) && sampled_q && (tx_neg_q ? i_neg_edge : i_pos_edge);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = START;
                    cnt_d   = len_start;
                end
            end
            START: state_d = XFER;
            XFER: begin
                if (sample_c) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched transfer settings and registered outputs decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_q      <= '0;
            tx_neg_q   <= 1'b0;
            sampled_q  <= 1'b0;
            o_divider  <= '0;
            o_enable   <= 1'b0;
            o_tx_start <= 1'b0;
            o_last_clk <= 1'b0;
            o_ss_n     <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_rx_data  <= '0;
        end else begin
            if (start_ok) begin
                len_q     <= len_start;
                tx_neg_q  <= i_tx_neg;
                o_divider <= i_divider;
                sampled_q <= 1'b0;
            end else if (sample_c) begin
                sampled_q <= 1'b1;
            end
            o_enable   <= (state_d == XFER);
            o_tx_start <= (state_d == START);
            o_last_clk <= ((state_d == START) || (state_d == XFER)) && (cnt_d == CNT_W'(1));
            o_ss_n     <= !((state_d == START) || (state_d == XFER));
            o_busy     <= (state_d != IDLE);
            o_done     <= (state_d == DONE);
            if ((state_q == XFER) && (state_d == DONE)) begin
                o_rx_data <= rx_next;
            end
        end
    end

    spi_shift_reg #(
        .MAX_CHAR (SPI_MAX_CHAR),
        .CNT_W    (CNT_W)
    ) u_shift (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (start_ok),
        .i_tx_load   (tx_load),
        .i_lsb       (lsb_start),
        .i_len       (len_q),
        .i_tx_shift  (drive_c),
        .i_rx_shift  (sample_c),
        .i_miso      (i_miso),
        .o_mosi      (o_mosi),
        .o_rx_next_c (rx_next)
    );

endmodule
